// File: rtl/sqrt_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_req_ctrl
// Purpose  : Request-side controller that issues sqrt/inv-sqrt commands to
//            core_SQRT and returns its result over a valid/ready response port.
// Revision : 1.0  initial release
// ============================================================================
module sqrt_req_ctrl #(
    parameter int DATA_W  = 9,
    parameter int MIN_LAT = 7,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_op_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              core_DoSqrt_o,
    output logic              core_DoInvSqrt_o,
    output logic [DATA_W-1:0] core_s_o,
    input  logic [DATA_W-1:0] core_res_i,
    input  logic              core_valid_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_op_o,
    output logic              rsp_timeout_o,
    output logic              rsp_dz_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op;
    logic               r_do_sqrt;
    logic               r_do_inv;
    logic [DATA_W-1:0]  r_core_s;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_op;
    logic               r_rsp_timeout;
    logic               r_rsp_dz;
    logic               r_busy;

    logic               w_req_hs;
    logic               w_rsp_hs;
    logic               w_dz;
    logic               w_capture;
    logic               w_timeout;

    // Ready is held low for the whole time reset is asserted.
    assign req_ready_o = rst & (r_state == S_IDLE);
    assign w_req_hs    = req_valid_i & req_ready_o;
    assign w_rsp_hs    = (r_state == S_RESP) & rsp_ready_i;
    assign w_dz        = req_op_i & (req_data_i == '0);

    // Valid seen before MIN_LAT may be left over from a prior op.
    assign w_capture   = (r_state == S_WAIT) & core_valid_i
                       & (r_cnt >= CNT_W'(MIN_LAT));
    assign w_timeout   = (r_state == S_WAIT) & ~w_capture
                       & (r_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req_hs) w_next = w_dz ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_capture || w_timeout) w_next = S_RESP;
            S_RESP:  if (w_rsp_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_op          <= 1'b0;
            r_do_sqrt     <= 1'b0;
            r_do_inv      <= 1'b0;
            r_core_s      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_op      <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_dz      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_do_sqrt <= 1'b0;
            r_do_inv  <= 1'b0;
            r_busy    <= (w_next != S_IDLE);

            if (w_req_hs) begin
                r_op <= req_op_i;
                if (w_dz) begin
                    r_rsp_valid   <= 1'b1;
                    r_rsp_dz      <= 1'b1;
                    r_rsp_timeout <= 1'b0;
                    r_rsp_data    <= '1;
                    r_rsp_op      <= 1'b1;
                end else begin
                    r_core_s  <= req_data_i;
                    r_do_sqrt <= ~req_op_i;
                    r_do_inv  <= req_op_i;
                end
            end

            if (r_state == S_ISSUE) begin
                r_cnt <= CNT_W'(1);
            end else if (w_capture || w_timeout) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_capture) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_data    <= core_res_i;
                r_rsp_op      <= r_op;
                r_rsp_timeout <= 1'b0;
                r_rsp_dz      <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_data    <= '0;
                r_rsp_op      <= r_op;
                r_rsp_timeout <= 1'b1;
                r_rsp_dz      <= 1'b0;
            end

            // Data and op stay as last delivered; only the flags drop.
            if (w_rsp_hs) begin
                r_rsp_valid   <= 1'b0;
                r_rsp_timeout <= 1'b0;
                r_rsp_dz      <= 1'b0;
            end
        end
    end

    assign core_DoSqrt_o    = r_do_sqrt;
    assign core_DoInvSqrt_o = r_do_inv;
    assign core_s_o         = r_core_s;
    assign rsp_valid_o      = r_rsp_valid;
    assign rsp_data_o       = r_rsp_data;
    assign rsp_op_o         = r_rsp_op;
    assign rsp_timeout_o    = r_rsp_timeout;
    assign rsp_dz_o         = r_rsp_dz;
    assign busy_o           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_req_ctrl
// Purpose  : Directed self-checking bench for sqrt_req_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_sqrt_req_ctrl;

    localparam int DATA_W = 9;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [DATA_W-1:0] req_data;
    logic              do_sqrt;
    logic              do_inv;
    logic [DATA_W-1:0] core_s;
    logic [DATA_W-1:0] core_res;
    logic              core_valid;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_op;
    logic              rsp_timeout;
    logic              rsp_dz;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    sqrt_req_ctrl #(.DATA_W(DATA_W), .MIN_LAT(7), .TIMEOUT(32)) u_dut (
        .clk              (clk),
        .rst              (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_op_i         (req_op),
        .req_data_i       (req_data),
        .core_DoSqrt_o    (do_sqrt),
        .core_DoInvSqrt_o (do_inv),
        .core_s_o         (core_s),
        .core_res_i       (core_res),
        .core_valid_i     (core_valid),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_data_o       (rsp_data),
        .rsp_op_o         (rsp_op),
        .rsp_timeout_o    (rsp_timeout),
        .rsp_dz_o         (rsp_dz),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Handshake happens on the first posedge; cycle k = k-th negedge after it.
    // valid_k = 0 means the core never answers.
    task automatic do_op(input string tag, input logic op, input logic [DATA_W-1:0] data,
                         input logic stale, input int valid_k, input logic [DATA_W-1:0] res,
                         input int exp_k, input logic [DATA_W-1:0] exp_data,
                         input logic exp_to, input logic exp_dz);
        int got_k;
        int pulses;
        int wrong;
        got_k  = 0;
        pulses = 0;
        wrong  = 0;
        if (stale) begin
            core_valid = 1'b1;
            core_res   = 9'h0AA;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        check({tag, "_req_ready"}, req_ready, 1);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1) req_valid = 1'b0;
            if (op ? do_inv : do_sqrt) pulses++;
            if (op ? do_sqrt : do_inv) wrong++;
            if (k == 1 && !exp_dz) check({tag, "_core_s"}, core_s, data);
            if (rsp_valid) begin
                got_k = k;
                break;
            end
            if (stale) begin
                core_res = (k >= valid_k) ? res : 9'h0AA;
            end else begin
                core_valid = (valid_k != 0) && (k == valid_k);
                core_res   = res;
            end
        end
        check({tag, "_latency"}, got_k, exp_k);
        check({tag, "_pulses"}, pulses, exp_dz ? 0 : 1);
        check({tag, "_wrong_pulse"}, wrong, 0);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_op"}, rsp_op, op);
        check({tag, "_timeout"}, rsp_timeout, exp_to);
        check({tag, "_dz"}, rsp_dz, exp_dz);
        check({tag, "_busy"}, busy, 1);
        core_valid = 1'b0;
        rsp_ready  = 1'b1;
        step();
        rsp_ready  = 1'b0;
        check({tag, "_rsp_clr"}, {rsp_valid, rsp_timeout, rsp_dz}, 0);
        check({tag, "_idle"}, {busy, req_ready}, 2'b01);
    endtask

    initial begin
        int k9;
        int viol;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 1'b0;
        req_data   = '0;
        core_res   = '0;
        core_valid = 1'b0;
        rsp_ready  = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_outs", {do_sqrt, do_inv, core_s, rsp_valid, rsp_data, rsp_op,
                           rsp_timeout, rsp_dz, busy}, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready", req_ready, 1);

        // 1: plain sqrt, core answers 7 cycles after the pulse
        do_op("sqrt", 1'b0, 9'h100, 1'b0, 8, 9'h100, 9, 9'h100, 1'b0, 1'b0);
        // 2: stale valid held high throughout
        do_op("stale", 1'b0, 9'h040, 1'b1, 8, 9'h0B5, 9, 9'h0B5, 1'b0, 1'b0);
        // 3: timeout on inverse sqrt
        do_op("tmo", 1'b1, 9'h080, 1'b0, 0, 9'h000, 34, 9'h000, 1'b1, 1'b0);
        // 4: inverse sqrt of zero bypasses the core
        do_op("dz", 1'b1, 9'h000, 1'b0, 0, 9'h000, 1, 9'h1FF, 1'b0, 1'b1);

        // 5: backpressure with a competing request held on the input
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_data  = 9'h000;
        step();
        req_op    = 1'b0;
        req_data  = 9'h055;
        viol = 0;
        for (int k = 0; k < 5; k++) begin
            if (!(rsp_valid && rsp_dz && rsp_data == 9'h1FF && rsp_op && !rsp_timeout
                  && !req_ready && busy && !do_sqrt && !do_inv)) viol++;
            step();
        end
        check("bp_stable", viol, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_released", {rsp_valid, req_ready}, 2'b01);
        core_valid = 1'b1;
        core_res   = 9'h123;
        step();
        req_valid = 1'b0;
        check("bp_pulse", {do_sqrt, do_inv}, 2'b10);
        check("bp_core_s", core_s, 9'h055);
        k9 = 0;
        for (int k = 2; k <= 20; k++) begin
            step();
            if (rsp_valid) begin
                k9 = k;
                break;
            end
        end
        check("bp_latency", k9, 9);
        check("bp_data", rsp_data, 9'h123);
        core_valid = 1'b0;
        rsp_ready  = 1'b1;
        step();
        rsp_ready  = 1'b0;

        // 6: async reset in WAIT at count 3
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = 9'h0C3;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        check("pre_rst_busy", {busy, core_s}, {1'b1, 9'h0C3});
        rst_n = 1'b0;
        #1;
        check("arst_ready", req_ready, 0);
        check("arst_outs", {do_sqrt, do_inv, core_s, rsp_valid, rsp_data, rsp_op,
                            rsp_timeout, rsp_dz, busy}, 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rel_idle", {busy, req_ready}, 2'b01);
        viol = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            core_valid = (k == 3);
            core_res   = 9'h077;
            if (rsp_valid || do_sqrt || do_inv || busy || !req_ready) viol++;
        end
        check("late_valid_ignored", viol, 0);
        core_valid = 1'b0;

        do_op("recover", 1'b0, 9'h1A0, 1'b0, 10, 9'h0D5, 11, 9'h0D5, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
